// File: rtl/imem_flash_controller.sv
// Instruction memory flash sequencer: accepts 32-bit words from the loader,
// writes each as four little-endian byte writes, then releases the memory
// address port to the core and lets it run.
module imem_flash_controller #(
    parameter int unsigned MEM_BYTES = 128,
    parameter logic [63:0] BASE_ADDR = 64'd0
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        startLoad,
    input  logic        wordValid,
    input  logic [31:0] wordData,
    input  logic        wordLast,
    output logic        wordReady,
    input  logic [63:0] cpuPc,
    output logic [63:0] memPc,
    output logic        flashEn,
    output logic [7:0]  flashInstruction,
    output logic [63:0] flashAddr,
    output logic        cpuRun,
    output logic        loadBusy,
    output logic        overflowErr,
    output logic [31:0] wordCount
);

    localparam int unsigned ADDR_W     = 64;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned WORD_BYTES = 4;

    // One extra bit so the bounds compare cannot be fooled by 64-bit wrap.
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        WRITE,
        RUN,
        ERROR
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [WORD_W-1:0]   word_q;
    logic                last_q;
    logic [IDX_W-1:0]    byte_idx;

    logic [IDX_W-1:0]    byte_idx_next_c;
    logic [ADDR_W:0]     word_end_c;
    logic                overflow_c;

    // Address port belongs to the flasher only while a byte is being written.
    assign memPc = flashEn ? flashAddr : cpuPc;

    // Next byte lane and whole-word bounds check against the memory depth.
    assign byte_idx_next_c = byte_idx + IDX_W'(1);
    assign word_end_c      = {1'b0, ptr} + (ADDR_W + 1)'(WORD_BYTES);
    assign overflow_c      = word_end_c > MEM_LIMIT;

    // Session FSM with all control outputs registered alongside the state.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state            <= IDLE;
            ptr              <= BASE_ADDR;
            word_q           <= '0;
            last_q           <= 1'b0;
            byte_idx         <= '0;
            wordReady        <= 1'b0;
            flashEn          <= 1'b0;
            flashInstruction <= '0;
            flashAddr        <= BASE_ADDR;
            cpuRun           <= 1'b0;
            loadBusy         <= 1'b0;
            overflowErr      <= 1'b0;
            wordCount        <= '0;
        end else begin
            case (state)
                IDLE, RUN, ERROR: begin
                    if (startLoad) begin
                        state       <= ACCEPT;
                        ptr         <= BASE_ADDR;
                        wordCount   <= '0;
                        loadBusy    <= 1'b1;
                        overflowErr <= 1'b0;
                        cpuRun      <= 1'b0;
                        wordReady   <= 1'b1;
                        flashEn     <= 1'b0;
                    end
                end

                ACCEPT: begin
                    if (wordValid && wordReady) begin
                        word_q    <= wordData;
                        last_q    <= wordLast;
                        wordReady <= 1'b0;
                        if (overflow_c) begin
                            // Refuse the whole word so no partial word lands in memory.
                            state       <= ERROR;
                            overflowErr <= 1'b1;
                            loadBusy    <= 1'b0;
                        end else begin
                            state            <= WRITE;
                            byte_idx         <= '0;
                            flashEn          <= 1'b1;
                            flashAddr        <= ptr;
                            flashInstruction <= wordData[BYTE_W-1:0];
                        end
                    end
                end

                WRITE: begin
                    if (byte_idx == IDX_W'(WORD_BYTES - 1)) begin
                        flashEn   <= 1'b0;
                        byte_idx  <= '0;
                        ptr       <= ptr + ADDR_W'(WORD_BYTES);
                        wordCount <= wordCount + 32'd1;
                        if (last_q) begin
                            state    <= RUN;
                            cpuRun   <= 1'b1;
                            loadBusy <= 1'b0;
                        end else begin
                            state     <= ACCEPT;
                            wordReady <= 1'b1;
                        end
                    end else begin
                        byte_idx         <= byte_idx_next_c;
                        flashAddr        <= ptr + ADDR_W'(byte_idx_next_c);
                        flashInstruction <= word_q[{byte_idx_next_c, 3'b000} +: BYTE_W];
                    end
                end

                default: begin
                    state     <= IDLE;
                    wordReady <= 1'b0;
                    flashEn   <= 1'b0;
                    cpuRun    <= 1'b0;
                    loadBusy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_flash_controller.sv
// Scoreboard bench for imem_flash_controller: expected byte writes are queued
// when a word is handed over and retired as the controller flashes them.
module tb_imem_flash_controller;

    localparam int unsigned MEM_BYTES = 8;
    localparam logic [63:0] BASE_ADDR = 64'd0;
    localparam int          TIMEOUT   = 60;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        startLoad = 1'b0;
    logic        wordValid = 1'b0;
    logic [31:0] wordData = '0;
    logic        wordLast = 1'b0;
    logic        wordReady;
    logic [63:0] cpuPc = '0;
    logic [63:0] memPc;
    logic        flashEn;
    logic [7:0]  flashInstruction;
    logic [63:0] flashAddr;
    logic        cpuRun;
    logic        loadBusy;
    logic        overflowErr;
    logic [31:0] wordCount;

    imem_flash_controller #(
        .MEM_BYTES(MEM_BYTES),
        .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk              (clk),
        .rstN             (rstN),
        .startLoad        (startLoad),
        .wordValid        (wordValid),
        .wordData         (wordData),
        .wordLast         (wordLast),
        .wordReady        (wordReady),
        .cpuPc            (cpuPc),
        .memPc            (memPc),
        .flashEn          (flashEn),
        .flashInstruction (flashInstruction),
        .flashAddr        (flashAddr),
        .cpuRun           (cpuRun),
        .loadBusy         (loadBusy),
        .overflowErr      (overflowErr),
        .wordCount        (wordCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          accept_count = 0;
    int          last_accept_cyc = 0;
    int          accept_gap = 0;
    int          acc_base = 0;
    logic [63:0] model_ptr = BASE_ADDR;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Retire expected byte writes and track the handshake cadence.
    always @(negedge clk) begin
        cyc++;
        if (rstN && wordValid && wordReady) begin
            accept_count++;
            accept_gap      = cyc - last_accept_cyc;
            last_accept_cyc = cyc;
        end
        if (flashEn) begin
            check_eq("write_expected", 64'(exp_q.size() != 0), 64'd1);
            check_eq("ready_in_write", 64'(wordReady), 64'd0);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check_eq("flash_addr", flashAddr, mon_e.addr);
                check_eq("flash_byte", 64'(flashInstruction), 64'(mon_e.data));
                check_eq("mempc_write", memPc, mon_e.addr);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        startLoad = 1'b1;
        @(negedge clk);
        startLoad = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic l, input bit ovf, input bit keep);
        int n = 0;
        wordValid = 1'b1;
        wordData  = d;
        wordLast  = l;
        while (wordReady !== 1'b1 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept_timeout", 64'(n < TIMEOUT), 64'd1);
        if (!ovf) begin
            for (int k = 0; k < 4; k++)
                exp_q.push_back('{addr: model_ptr + 64'(k), data: d[8*k +: 8]});
            model_ptr = model_ptr + 64'd4;
        end
        @(posedge clk);
        #1;
        if (!keep) wordValid = 1'b0;
    endtask

    task automatic wait_run();
        int n = 0;
        while (cpuRun !== 1'b1 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check_eq("run_timeout", 64'(n < TIMEOUT), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        cpuPc = 64'h1234;
        #12;
        check_eq("rst_ready", 64'(wordReady), 64'd0);
        check_eq("rst_flash_en", 64'(flashEn), 64'd0);
        check_eq("rst_flash_byte", 64'(flashInstruction), 64'd0);
        check_eq("rst_flash_addr", flashAddr, BASE_ADDR);
        check_eq("rst_cpu_run", 64'(cpuRun), 64'd0);
        check_eq("rst_busy", 64'(loadBusy), 64'd0);
        check_eq("rst_ovf", 64'(overflowErr), 64'd0);
        check_eq("rst_count", 64'(wordCount), 64'd0);
        check_eq("rst_mempc", memPc, 64'h1234);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        check_eq("idle_ready", 64'(wordReady), 64'd0);
        check_eq("idle_busy", 64'(loadBusy), 64'd0);

        // Two-word session ending in RUN
        model_ptr = BASE_ADDR;
        pulse_start();
        check_eq("start_busy", 64'(loadBusy), 64'd1);
        check_eq("start_ready", 64'(wordReady), 64'd1);
        send_word(32'h00003083, 1'b0, 1'b0, 1'b0);
        send_word(32'h00803103, 1'b1, 1'b0, 1'b0);
        wait_run();
        check_eq("s1_run", 64'(cpuRun), 64'd1);
        check_eq("s1_busy", 64'(loadBusy), 64'd0);
        check_eq("s1_count", 64'(wordCount), 64'd2);
        check_eq("s1_ready", 64'(wordReady), 64'd0);
        check_eq("s1_missing", 64'(exp_q.size()), 64'd0);

        // RUN: memPc follows the core and stray words are ignored
        cpuPc     = 64'h10;
        wordValid = 1'b1;
        wordData  = 32'hdeadbeef;
        repeat (3) @(negedge clk);
        check_eq("run_mempc", memPc, 64'h10);
        check_eq("run_ignore_count", 64'(wordCount), 64'd2);
        check_eq("run_hold", 64'(cpuRun), 64'd1);
        wordValid = 1'b0;
        model_ptr = BASE_ADDR;
        pulse_start();
        check_eq("restart_run_drop", 64'(cpuRun), 64'd0);
        check_eq("restart_busy", 64'(loadBusy), 64'd1);
        check_eq("restart_count", 64'(wordCount), 64'd0);

        // Backpressure: wordValid held through the writes
        acc_base = accept_count;
        send_word(32'h11223344, 1'b0, 1'b0, 1'b1);
        send_word(32'h55667788, 1'b1, 1'b0, 1'b0);
        wait_run();
        check_eq("bp_accepts", 64'(accept_count - acc_base), 64'd2);
        check_eq("bp_gap", 64'(accept_gap), 64'd5);
        check_eq("bp_count", 64'(wordCount), 64'd2);
        check_eq("bp_missing", 64'(exp_q.size()), 64'd0);

        // startLoad during byte 2 of a write is ignored
        model_ptr = BASE_ADDR;
        pulse_start();
        send_word(32'hcafef00d, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        startLoad = 1'b1;
        @(negedge clk);
        startLoad = 1'b0;
        check_eq("midwr_flash_en", 64'(flashEn), 64'd1);
        check_eq("midwr_busy", 64'(loadBusy), 64'd1);
        send_word(32'h0badc0de, 1'b1, 1'b0, 1'b0);
        wait_run();
        check_eq("midwr_count", 64'(wordCount), 64'd2);
        check_eq("midwr_missing", 64'(exp_q.size()), 64'd0);

        // Overflow on the third word of an 8-byte memory
        model_ptr = BASE_ADDR;
        pulse_start();
        send_word(32'ha1a2a3a4, 1'b0, 1'b0, 1'b0);
        send_word(32'hb1b2b3b4, 1'b0, 1'b0, 1'b0);
        send_word(32'hc1c2c3c4, 1'b1, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        check_eq("ovf_err", 64'(overflowErr), 64'd1);
        check_eq("ovf_busy", 64'(loadBusy), 64'd0);
        check_eq("ovf_run", 64'(cpuRun), 64'd0);
        check_eq("ovf_ready", 64'(wordReady), 64'd0);
        check_eq("ovf_count", 64'(wordCount), 64'd2);
        check_eq("ovf_missing", 64'(exp_q.size()), 64'd0);
        model_ptr = BASE_ADDR;
        pulse_start();
        check_eq("ovf_clear", 64'(overflowErr), 64'd0);
        check_eq("ovf_restart_busy", 64'(loadBusy), 64'd1);
        check_eq("ovf_restart_count", 64'(wordCount), 64'd0);

        // Asynchronous reset in the middle of a write
        send_word(32'h01020304, 1'b0, 1'b0, 1'b0);
        #2;
        rstN = 1'b0;
        #1;
        check_eq("arst_flash_en", 64'(flashEn), 64'd0);
        check_eq("arst_run", 64'(cpuRun), 64'd0);
        check_eq("arst_ready", 64'(wordReady), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rstN = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("post_rst_ready", 64'(wordReady), 64'd0);
        check_eq("post_rst_busy", 64'(loadBusy), 64'd0);
        check_eq("post_rst_count", 64'(wordCount), 64'd0);

        // Single-word session straight to RUN
        model_ptr = BASE_ADDR;
        pulse_start();
        check_eq("one_ready", 64'(wordReady), 64'd1);
        send_word(32'ha5a55a5a, 1'b1, 1'b0, 1'b0);
        wait_run();
        check_eq("one_count", 64'(wordCount), 64'd1);
        check_eq("one_run", 64'(cpuRun), 64'd1);
        check_eq("one_missing", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
